alu_operand_issue: RTL and testbench
====================================

ALU_OPERAND_ISSUE -- requirements
Module: alu_operand_issue

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock domain.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  decoded instruction present; in_ready  output  1  stage accepts it.
REQ-004 rs1_addr, rs2_addr, rd_addr  input  5 each  source/destination register indices.
REQ-005 rs1_data, rs2_data  input  32 each  register-file read data.
REQ-006 imm, pc  input  32 each  immediate and instruction address.
REQ-007 op1_sel  input  2  operand-1 source (REG/PC/ZERO); op2_sel  input  2  operand-2 source (REG/IMM/FOUR).
REQ-008 func_in  input  4  ALU operation code; reg_write_in  input  1; mem_read_in  input  1.
REQ-009 ex_rd  input  5; ex_reg_write  input  1; ex_mem_read  input  1; ex_result  input  32  (ALU result fed back from EX).
REQ-010 mem_rd  input  5; mem_reg_write  input  1; mem_result  input  32  (MEM-stage writeback value).
REQ-011 flush  input  1  discard the held and incoming instruction.
REQ-012 out_valid  output  1; out_ready  input  1  ALU-side handshake.
REQ-013 op1, op2  output  32 each; ALU_func  output  4; rd_out  output  5; reg_write_out, mem_read_out  output  1 each.

Function
REQ-014 Output register stage; states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 Transfer in occurs at a rising edge with in_valid && in_ready; transfer out with out_valid && out_ready.
REQ-016 in_ready = !hazard && (!out_valid || out_ready) && !flush; same-cycle out/in transfer keeps FULL with new contents (full throughput).
REQ-017 EMPTY->FULL on transfer in; FULL->EMPTY on transfer out without transfer in; FULL holds all outputs stable while out_ready=0.
REQ-018 Latency exactly one cycle: values captured at edge N appear on outputs after edge N.
REQ-019 Per source, resolved value priority: index 0 -> 32'h0; EX match (ex_reg_write, ex_rd==idx, !ex_mem_read) -> ex_result; MEM match (mem_reg_write, mem_rd==idx) -> mem_result; else register-file data.
REQ-020 hazard = in_valid && ex_mem_read && ex_reg_write && ex_rd!=0 && ex_rd equals a source actually selected (rs1 when op1_sel=REG, rs2 when op2_sel=REG); while high, in_ready=0 and the instruction waits.
REQ-021 op1 = resolved rs1 / pc / 0 per op1_sel; op2 = resolved rs2 / imm / 32'd4 per op2_sel; unused sel codes -> 0.
REQ-022 ALU_func, rd_out, reg_write_out, mem_read_out registered from func_in, rd_addr, reg_write_in, mem_read_in.
REQ-023 flush at an edge forces EMPTY and clears reg_write_out, mem_read_out, overriding any simultaneous transfer in.
REQ-024 When out_valid=0, reg_write_out=0 and mem_read_out=0 (bubbles never write).
REQ-025 All arithmetic is 32-bit; no widening or truncation beyond selection.

Reset
REQ-026 rst_n low immediately forces EMPTY; op1, op2=32'h0; ALU_func=ADD code; rd_out=0; reg_write_out, mem_read_out=0.
REQ-027 Reset asserted mid-transfer discards the instruction; first transfer in is permitted at the first edge after rst_n deasserts.

Structure
REQ-028 ALU_func operation codes and op1_sel/op2_sel codes live in the shared Parameters definitions; no local redefinition.
REQ-029 One sub-module forward_mux (one instance per source) implements REQ-019 combinationally.

Verification
REQ-030 rs1=5 (data 10), op2_sel=IMM imm=7, func ADD, out_ready=1 -> next cycle out_valid=1, op1=10, op2=7.
REQ-031 rs1=3 with ex_rd=3, ex_result=0x55 and mem_rd=3, mem_result=0x66 -> op1=0x55 (EX priority); rs1=0 with ex_rd=0 -> op1=0.
REQ-032 ex_mem_read=1, ex_rd=4, incoming rs2=4, op2_sel=REG -> in_ready=0 that cycle; ex_mem_read drops next cycle -> accepted.
REQ-033 FULL with out_ready=0 for 3 cycles -> op1/op2/ALU_func unchanged, in_ready=0; out_ready=1 with in_valid -> back-to-back transfer.
REQ-034 flush while FULL and in_valid=1 -> next cycle out_valid=0, reg_write_out=0.
REQ-035 rst_n low while FULL -> out_valid=0, op1=op2=0 without waiting for a clock edge.

Source files
------------

// File: rtl/alu_operand_issue_pkg.sv
// Shared definitions for the ALU operand-issue stage.
// Holds the ALU operation codes, the operand-source select codes and the
// two-state occupancy encoding of the output register.
package alu_operand_issue_pkg;

  // ALU operation codes carried on func_in / ALU_func.
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;

  // Operand-1 sources; code 3 is unused and selects zero.
  localparam logic [1:0] OP1_REG  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;

  // Operand-2 sources; code 3 is unused and selects zero.
  localparam logic [1:0] OP2_REG  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_FOUR = 2'd2;

  // Occupancy of the output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } issue_state_t;

endpackage

// File: rtl/alu_operand_issue_forward_mux.sv
// forward_mux: resolves one register source against the in-flight results.
// Ports:
//   idx           source register index
//   rf_data       register-file read data for idx
//   ex_*          destination/result of the instruction in EX
//   mem_*         destination/result of the instruction in MEM
//   value         resolved operand value
// Priority: x0 is hardwired zero, then EX (only when EX is not a load,
// since a load's data is not yet available), then MEM, then the register file.
module forward_mux (
  input  logic [4:0]  idx,
  input  logic [31:0] rf_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [31:0] ex_result,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  output logic [31:0] value
);

  always_comb begin
    value = rf_data;
    if (idx == 5'd0) begin
      value = 32'h0;
    end else if (ex_reg_write && (ex_rd == idx) && !ex_mem_read) begin
      value = ex_result;
    end else if (mem_reg_write && (mem_rd == idx)) begin
      value = mem_result;
    end
  end

endmodule

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: operand selection, forwarding and load-use stall in
// front of the ALU, ending in a single ready/valid output register.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid / in_ready                 decoded-instruction handshake
//   rs1_addr, rs2_addr, rd_addr         register indices
//   rs1_data, rs2_data, imm, pc         operand sources
//   op1_sel, op2_sel                    operand source selects
//   func_in, reg_write_in, mem_read_in  control carried to the ALU
//   ex_*, mem_*                         forwarding / hazard inputs
//   flush                               drop held and incoming instruction
//   out_valid / out_ready               ALU-side handshake
//   op1, op2, ALU_func, rd_out,
//   reg_write_out, mem_read_out         registered outputs
module alu_operand_issue
  import alu_operand_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic [1:0]  op1_sel,
  input  logic [1:0]  op2_sel,
  input  logic [3:0]  func_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [31:0] ex_result,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [3:0]  ALU_func,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_read_out
);

  issue_state_t state_reg, state_next;
  logic [31:0]  rs1_fwd, rs2_fwd;
  logic [31:0]  op1_next, op2_next;
  logic         hazard;
  logic         load;

  logic [31:0]  op1_reg, op2_reg;
  logic [3:0]   func_reg;
  logic [4:0]   rd_reg;
  logic         reg_write_reg, mem_read_reg;

  forward_mux u_fwd_rs1 (
    .idx           (rs1_addr),
    .rf_data       (rs1_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_result     (ex_result),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .value         (rs1_fwd)
  );

  forward_mux u_fwd_rs2 (
    .idx           (rs2_addr),
    .rf_data       (rs2_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_result     (ex_result),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .value         (rs2_fwd)
  );

  // Load-use stall: only a source that is actually routed to an operand can
  // create a dependency on the load in EX.
  assign hazard = in_valid && ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
                  (((op1_sel == OP1_REG) && (ex_rd == rs1_addr)) ||
                   ((op2_sel == OP2_REG) && (ex_rd == rs2_addr)));

  assign out_valid = (state_reg == ST_FULL);
  assign in_ready  = !hazard && (!out_valid || out_ready) && !flush;
  assign load      = in_valid && in_ready;

  always_comb begin
    op1_next = 32'h0;
    case (op1_sel)
      OP1_REG:  op1_next = rs1_fwd;
      OP1_PC:   op1_next = pc;
      default:  op1_next = 32'h0;
    endcase
  end

  always_comb begin
    op2_next = 32'h0;
    case (op2_sel)
      OP2_REG:  op2_next = rs2_fwd;
      OP2_IMM:  op2_next = imm;
      OP2_FOUR: op2_next = 32'd4;
      default:  op2_next = 32'h0;
    endcase
  end

  // Occupancy: load always leaves the stage FULL (covers simultaneous
  // drain + refill); flush wins over everything, and in_ready already
  // blocks a load during flush.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (load) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !load) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
    if (flush) state_next = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      op1_reg       <= 32'h0;
      op2_reg       <= 32'h0;
      func_reg      <= ALU_ADD;
      rd_reg        <= 5'd0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        op1_reg       <= op1_next;
        op2_reg       <= op2_next;
        func_reg      <= func_in;
        rd_reg        <= rd_addr;
        reg_write_reg <= reg_write_in;
        mem_read_reg  <= mem_read_in;
      end else if (state_next == ST_EMPTY) begin
        // A bubble must never write back or issue a load.
        reg_write_reg <= 1'b0;
        mem_read_reg  <= 1'b0;
      end
    end
  end

  assign op1           = op1_reg;
  assign op2           = op2_reg;
  assign ALU_func      = func_reg;
  assign rd_out        = rd_reg;
  assign reg_write_out = reg_write_reg;
  assign mem_read_out  = mem_read_reg;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Testbench for alu_operand_issue: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a queue-based model.
module tb_alu_operand_issue;
  import alu_operand_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic [1:0]  op1_sel, op2_sel;
  logic [3:0]  func_in;
  logic        reg_write_in, mem_read_in;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read;
  logic [31:0] ex_result;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] op1, op2;
  logic [3:0]  ALU_func;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_read_out;

  always #5 clk = ~clk;

  alu_operand_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .func_in(func_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_result(ex_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op1(op1), .op2(op2), .ALU_func(ALU_func),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  func;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
  } entry_t;

  entry_t held[$];   // at most one instruction held in the output stage
  logic   rdy_seen;

  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'h0;
    if (ex_reg_write && ex_rd == idx && !ex_mem_read) return ex_result;
    if (mem_reg_write && mem_rd == idx) return mem_result;
    return rf;
  endfunction

  function automatic logic model_ready();
    logic uses1, uses2, stall;
    uses1 = (op1_sel == OP1_REG) && (rs1_addr == ex_rd);
    uses2 = (op2_sel == OP2_REG) && (rs2_addr == ex_rd);
    stall = in_valid && ex_mem_read && ex_reg_write && ex_rd != 5'd0 && (uses1 || uses2);
    return !stall && (held.size() == 0 || out_ready) && !flush;
  endfunction

  function automatic entry_t model_entry();
    entry_t e;
    e.op1 = (op1_sel == OP1_REG) ? resolve(rs1_addr, rs1_data) :
            (op1_sel == OP1_PC)  ? pc : 32'h0;
    e.op2 = (op2_sel == OP2_REG)  ? resolve(rs2_addr, rs2_data) :
            (op2_sel == OP2_IMM)  ? imm :
            (op2_sel == OP2_FOUR) ? 32'd4 : 32'h0;
    e.func = func_in;
    e.rd   = rd_addr;
    e.rw   = reg_write_in;
    e.mr   = mem_read_in;
    return e;
  endfunction

  // One clock: called at a negedge with inputs already driven.
  task automatic step();
    logic   exp_rdy, take, drain;
    entry_t e;
    #1;
    exp_rdy  = model_ready();
    rdy_seen = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    e     = model_entry();
    take  = in_valid && exp_rdy;
    drain = (held.size() != 0) && out_ready;
    @(posedge clk);
    if (rst_n) begin
      if (flush) held.delete();
      else begin
        if (drain) void'(held.pop_front());
        if (take) held.push_back(e);
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(held.size() != 0));
    if (held.size() != 0) begin
      chk("op1", op1, held[0].op1);
      chk("op2", op2, held[0].op2);
      chk("ALU_func", 32'(ALU_func), 32'(held[0].func));
      chk("rd_out", 32'(rd_out), 32'(held[0].rd));
      chk("reg_write_out", 32'(reg_write_out), 32'(held[0].rw));
      chk("mem_read_out", 32'(mem_read_out), 32'(held[0].mr));
    end else begin
      chk("bubble_reg_write", 32'(reg_write_out), 32'h0);
      chk("bubble_mem_read", 32'(mem_read_out), 32'h0);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    rs1_data = 0; rs2_data = 0; imm = 0; pc = 0;
    op1_sel = OP1_ZERO; op2_sel = OP2_FOUR; func_in = ALU_ADD;
    reg_write_in = 0; mem_read_in = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_result = 0;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_op1"}, op1, 32'h0);
    chk({tag, "_op2"}, op2, 32'h0);
    chk({tag, "_func"}, 32'(ALU_func), 32'(ALU_ADD));
    chk({tag, "_rd"}, 32'(rd_out), 32'h0);
    chk({tag, "_reg_write"}, 32'(reg_write_out), 32'h0);
    chk({tag, "_mem_read"}, 32'(mem_read_out), 32'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm_v, pc_v;
    logic [1:0]  s1, s2;
    logic [4:0]  erd;
    logic        erw, emr;
    logic [31:0] eres;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] mres;
    logic [31:0] exp_op1, exp_op2;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // basic reg + immediate
    tbl[0] = '{5'd5, 5'd0, 32'd10, 32'h0, 32'd7, 32'h0, OP1_REG, OP2_IMM,
               5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'd10, 32'd7};
    // EX beats MEM
    tbl[1] = '{5'd3, 5'd0, 32'h11, 32'h0, 32'h0, 32'h0, OP1_REG, OP2_FOUR,
               5'd3, 1'b1, 1'b0, 32'h55, 5'd3, 1'b1, 32'h66, 32'h55, 32'd4};
    // x0 never forwards
    tbl[2] = '{5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 32'h0, OP1_REG, OP2_REG,
               5'd0, 1'b1, 1'b0, 32'h55, 5'd0, 1'b1, 32'h66, 32'h0, 32'h0};
    // MEM forwarding only
    tbl[3] = '{5'd3, 5'd9, 32'h11, 32'h77, 32'h0, 32'h0, OP1_REG, OP2_REG,
               5'd3, 1'b0, 1'b0, 32'h55, 5'd3, 1'b1, 32'h66, 32'h66, 32'h77};
    // EX load on an unselected source: no stall, PC route
    tbl[4] = '{5'd6, 5'd7, 32'h11, 32'h22, 32'h0, 32'h400, OP1_PC, OP2_REG,
               5'd6, 1'b1, 1'b1, 32'h55, 5'd0, 1'b0, 32'h0, 32'h400, 32'h22};
    // zero / four
    tbl[5] = '{5'd1, 5'd2, 32'h11, 32'h22, 32'h33, 32'h44, OP1_ZERO, OP2_FOUR,
               5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'd4};
    // unused select codes give zero
    tbl[6] = '{5'd1, 5'd2, 32'h11, 32'h22, 32'h33, 32'h44, 2'd3, 2'd3,
               5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0};
  end

  // ---------------- test sequence ----------------
  initial begin
    idle_inputs();
    rst_n = 0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // first transfer right after reset release
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      rs1_addr = tbl[i].rs1; rs2_addr = tbl[i].rs2;
      rs1_data = tbl[i].d1;  rs2_data = tbl[i].d2;
      imm = tbl[i].imm_v; pc = tbl[i].pc_v;
      op1_sel = tbl[i].s1; op2_sel = tbl[i].s2;
      ex_rd = tbl[i].erd; ex_reg_write = tbl[i].erw; ex_mem_read = tbl[i].emr;
      ex_result = tbl[i].eres;
      mem_rd = tbl[i].mrd; mem_reg_write = tbl[i].mrw; mem_result = tbl[i].mres;
      rd_addr = 5'(i + 1); func_in = ALU_SUB; reg_write_in = 1;
      in_valid = 1;
      step();
      chk($sformatf("tbl%0d_accept", i), 32'(rdy_seen), 32'h1);
      chk($sformatf("tbl%0d_op1", i), op1, tbl[i].exp_op1);
      chk($sformatf("tbl%0d_op2", i), op2, tbl[i].exp_op2);
      idle_inputs();
      step();
    end

    // load-use stall, released when the load leaves EX
    idle_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd4; ex_result = 32'hABCD;
    rs2_addr = 5'd4; rs2_data = 32'h1234; op2_sel = OP2_REG; op1_sel = OP1_ZERO;
    in_valid = 1; reg_write_in = 1;
    step();
    chk("hazard_stall", 32'(rdy_seen), 32'h0);
    ex_mem_read = 0;
    step();
    chk("hazard_release", 32'(rdy_seen), 32'h1);
    chk("hazard_fwd_op2", op2, 32'hABCD);
    idle_inputs();
    step();

    // backpressure for three cycles, then back-to-back transfers
    idle_inputs();
    op1_sel = OP1_PC; op2_sel = OP2_IMM; pc = 32'h1000; imm = 32'h20;
    func_in = ALU_XOR; in_valid = 1;
    step();
    out_ready = 0; pc = 32'h2000; imm = 32'h30; func_in = ALU_OR;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_op1", op1, 32'h1000);
      chk("stall_op2", op2, 32'h20);
      chk("stall_func", 32'(ALU_func), 32'(ALU_XOR));
      chk("stall_ready", 32'(rdy_seen), 32'h0);
    end
    out_ready = 1;
    step();
    chk("b2b_ready", 32'(rdy_seen), 32'h1);
    chk("b2b_op1", op1, 32'h2000);
    pc = 32'h3000;
    step();
    chk("b2b2_valid", 32'(out_valid), 32'h1);
    chk("b2b2_op1", op1, 32'h3000);
    idle_inputs();
    step();

    // flush while FULL with a new instruction offered
    idle_inputs();
    op1_sel = OP1_PC; pc = 32'h500; reg_write_in = 1; in_valid = 1;
    step();
    flush = 1; out_ready = 0; pc = 32'h600;
    step();
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_reg_write", 32'(reg_write_out), 32'h0);
    idle_inputs();
    step();

    // asynchronous reset while FULL
    idle_inputs();
    op1_sel = OP1_PC; pc = 32'h44; op2_sel = OP2_IMM; imm = 32'h88;
    reg_write_in = 1; mem_read_in = 1; in_valid = 1;
    step();
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("async_reset");
    held.delete();
    @(negedge clk);
    rst_n = 1;
    step();
    chk("post_reset_accept", 32'(rdy_seen), 32'h1);
    idle_inputs();
    step();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      rs1_addr      = 5'($urandom_range(0, 3));
      rs2_addr      = 5'($urandom_range(0, 3));
      rd_addr       = 5'($urandom_range(0, 31));
      rs1_data      = $urandom;
      rs2_data      = $urandom;
      imm           = $urandom;
      pc            = $urandom;
      op1_sel       = 2'($urandom_range(0, 3));
      op2_sel       = 2'($urandom_range(0, 3));
      func_in       = 4'($urandom_range(0, 9));
      reg_write_in  = 1'($urandom_range(0, 1));
      mem_read_in   = 1'($urandom_range(0, 1));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = ($urandom_range(0, 2) == 0);
      ex_result     = $urandom;
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_result    = $urandom;
      flush         = ($urandom_range(0, 15) == 0);
      out_ready     = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
